// File: rtl/otter_alu_issue_pkg.sv
// Shared OTTER types: ALU op encoding, operand source selects and datapath widths.
// Imported by the issue stage, its forwarding resolver and the stage interface users.
package otter_pkg;

   localparam int XLEN = 32;
   localparam int RA_W = 5;

   localparam logic [15:0] STALL_MAX = 16'hFFFF;

   // ALU op is {func7[5], func3}; LUI reuses an unused slot to mean "copy a"
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SLL  = 4'd1,
      ALU_SLT  = 4'd2,
      ALU_SLTU = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SRL  = 4'd5,
      ALU_OR   = 4'd6,
      ALU_AND  = 4'd7,
      ALU_SUB  = 4'd8,
      ALU_LUI  = 4'd9,
      ALU_MUL  = 4'd10,
      ALU_SRA  = 4'd13
   } alu_op_t;

   typedef enum logic [1:0] {
      SRC_RS   = 2'd0,
      SRC_IMM  = 2'd1,
      SRC_PC   = 2'd2,
      SRC_ZERO = 2'd3
   } src_sel_t;

   function automatic logic [XLEN-1:0] pick_operand(
      input src_sel_t        sel,
      input logic [XLEN-1:0] rs,
      input logic [XLEN-1:0] imm,
      input logic [XLEN-1:0] pc
   );
      logic [XLEN-1:0] result;
      case (sel)
         SRC_RS:  result = rs;
         SRC_IMM: result = imm;
         SRC_PC:  result = pc;
         default: result = '0;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/otter_alu_issue_if.sv
// Decode-to-execute bus around the ID/EX stage: decoded fields in, registered ALU inputs out.
// master = the surrounding pipeline (decode + execute), slave = the issue stage.
interface otter_alu_issue_if #(
   parameter int XLEN = otter_pkg::XLEN,
   parameter int RA_W = otter_pkg::RA_W
);

   logic            id_valid;
   logic            id_ready;
   logic [3:0]      id_alu_op;
   logic [1:0]      id_a_sel;
   logic [1:0]      id_b_sel;
   logic [RA_W-1:0] id_rs1_addr;
   logic [RA_W-1:0] id_rs2_addr;
   logic [XLEN-1:0] id_rs1_data;
   logic [XLEN-1:0] id_rs2_data;
   logic [XLEN-1:0] id_imm;
   logic [XLEN-1:0] id_pc;
   logic [RA_W-1:0] id_rd_addr;
   logic            id_rd_we;
   logic            id_is_load;

   logic            ex_ready;
   logic [XLEN-1:0] ex_result;
   logic            ex_valid;
   logic [3:0]      ex_alu_op;
   logic [XLEN-1:0] ex_alu_a;
   logic [XLEN-1:0] ex_alu_b;
   logic [RA_W-1:0] ex_rd_addr;
   logic            ex_rd_we;
   logic            ex_is_load;

   modport master (
      output id_valid, id_alu_op, id_a_sel, id_b_sel,
             id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
             id_imm, id_pc, id_rd_addr, id_rd_we, id_is_load,
             ex_ready, ex_result,
      input  id_ready, ex_valid, ex_alu_op, ex_alu_a, ex_alu_b,
             ex_rd_addr, ex_rd_we, ex_is_load
   );

   modport slave (
      input  id_valid, id_alu_op, id_a_sel, id_b_sel,
             id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
             id_imm, id_pc, id_rd_addr, id_rd_we, id_is_load,
             ex_ready, ex_result,
      output id_ready, ex_valid, ex_alu_op, ex_alu_a, ex_alu_b,
             ex_rd_addr, ex_rd_we, ex_is_load
   );

endinterface

// File: rtl/otter_alu_issue_fwd_resolve.sv
// Resolves one source register through the EX/MEM/WB bypass network.
// Reports a hazard when the youngest matching producer cannot supply its value yet.
module otter_fwd_resolve #(
   parameter int XLEN = otter_pkg::XLEN,
   parameter int RA_W = otter_pkg::RA_W
) (
   input  logic            use_src,
   input  logic [RA_W-1:0] addr,
   input  logic [XLEN-1:0] rf_data,
   input  logic            ex_valid,
   input  logic            ex_rd_we,
   input  logic [RA_W-1:0] ex_rd_addr,
   input  logic            ex_is_load,
   input  logic [XLEN-1:0] ex_result,
   input  logic            mem_rd_we,
   input  logic [RA_W-1:0] mem_rd_addr,
   input  logic            mem_data_ok,
   input  logic [XLEN-1:0] mem_result,
   input  logic            wb_rd_we,
   input  logic [RA_W-1:0] wb_rd_addr,
   input  logic [XLEN-1:0] wb_data,
   output logic [XLEN-1:0] data,
   output logic            hazard
);

   logic ex_hit;
   logic mem_hit;
   logic wb_hit;

   assign ex_hit  = ex_valid && ex_rd_we && (ex_rd_addr == addr);
   assign mem_hit = mem_rd_we && (mem_rd_addr == addr);
   assign wb_hit  = wb_rd_we && (wb_rd_addr == addr);

   // Youngest producer wins even when it is not ready, so an older stale copy is never used
   always_comb begin
      data   = rf_data;
      hazard = 1'b0;
      if (addr == '0) begin
         data = '0;
      end else if (ex_hit) begin
         data   = ex_result;
         hazard = ex_is_load;
      end else if (mem_hit) begin
         data   = mem_result;
         hazard = !mem_data_ok;
      end else if (wb_hit) begin
         data = wb_data;
      end
      if (!use_src) begin
         hazard = 1'b0;
      end
   end

endmodule

// File: rtl/otter_alu_issue.sv
// ID/EX stage feeding the OTTER ALU: forwards operands, interlocks load-use hazards,
// and registers op/a/b behind a valid/ready handshake with flush support.
module otter_alu_issue #(
   parameter int XLEN = otter_pkg::XLEN,
   parameter int RA_W = otter_pkg::RA_W
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   otter_alu_issue_if.slave       bus,
   input  logic [RA_W-1:0]        mem_rd_addr,
   input  logic                   mem_rd_we,
   input  logic                   mem_data_ok,
   input  logic [XLEN-1:0]        mem_result,
   input  logic [RA_W-1:0]        wb_rd_addr,
   input  logic                   wb_rd_we,
   input  logic [XLEN-1:0]        wb_data,
   input  logic                   flush,
   output logic [15:0]            stall_cnt
);

   import otter_pkg::*;

   logic            ex_valid_q;
   logic [3:0]      ex_alu_op_q;
   logic [XLEN-1:0] ex_alu_a_q;
   logic [XLEN-1:0] ex_alu_b_q;
   logic [RA_W-1:0] ex_rd_addr_q;
   logic            ex_rd_we_q;
   logic            ex_is_load_q;

   src_sel_t        a_sel;
   src_sel_t        b_sel;
   logic            use1;
   logic            use2;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic            haz1;
   logic            haz2;
   logic            hazard;
   logic            advance;
   logic            accept;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;

   assign a_sel = src_sel_t'(bus.id_a_sel);
   assign b_sel = src_sel_t'(bus.id_b_sel);
   assign use1  = (a_sel == SRC_RS);
   assign use2  = (b_sel == SRC_RS);

   otter_fwd_resolve #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
      .use_src     (use1),
      .addr        (bus.id_rs1_addr),
      .rf_data     (bus.id_rs1_data),
      .ex_valid    (ex_valid_q),
      .ex_rd_we    (ex_rd_we_q),
      .ex_rd_addr  (ex_rd_addr_q),
      .ex_is_load  (ex_is_load_q),
      .ex_result   (bus.ex_result),
      .mem_rd_we   (mem_rd_we),
      .mem_rd_addr (mem_rd_addr),
      .mem_data_ok (mem_data_ok),
      .mem_result  (mem_result),
      .wb_rd_we    (wb_rd_we),
      .wb_rd_addr  (wb_rd_addr),
      .wb_data     (wb_data),
      .data        (rs1_val),
      .hazard      (haz1)
   );

   otter_fwd_resolve #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
      .use_src     (use2),
      .addr        (bus.id_rs2_addr),
      .rf_data     (bus.id_rs2_data),
      .ex_valid    (ex_valid_q),
      .ex_rd_we    (ex_rd_we_q),
      .ex_rd_addr  (ex_rd_addr_q),
      .ex_is_load  (ex_is_load_q),
      .ex_result   (bus.ex_result),
      .mem_rd_we   (mem_rd_we),
      .mem_rd_addr (mem_rd_addr),
      .mem_data_ok (mem_data_ok),
      .mem_result  (mem_result),
      .wb_rd_we    (wb_rd_we),
      .wb_rd_addr  (wb_rd_addr),
      .wb_data     (wb_data),
      .data        (rs2_val),
      .hazard      (haz2)
   );

   assign hazard  = haz1 || haz2;
   assign advance = !ex_valid_q || bus.ex_ready;
   assign accept  = advance && bus.id_valid && !hazard;
   assign op_a    = pick_operand(a_sel, rs1_val, bus.id_imm, bus.id_pc);
   assign op_b    = pick_operand(b_sel, rs2_val, bus.id_imm, bus.id_pc);

   // id_ready deliberately ignores id_valid so decode can rely on it without a loop
   assign bus.id_ready = advance && !hazard && !flush;

   // Pipeline register: flush beats capture, capture beats bubble, otherwise hold under backpressure
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ex_valid_q   <= 1'b0;
         ex_alu_op_q  <= '0;
         ex_alu_a_q   <= '0;
         ex_alu_b_q   <= '0;
         ex_rd_addr_q <= '0;
         ex_rd_we_q   <= 1'b0;
         ex_is_load_q <= 1'b0;
      end else if (flush) begin
         ex_valid_q <= 1'b0;
      end else if (accept) begin
         ex_valid_q   <= 1'b1;
         ex_alu_op_q  <= bus.id_alu_op;
         ex_alu_a_q   <= op_a;
         ex_alu_b_q   <= op_b;
         ex_rd_addr_q <= bus.id_rd_addr;
         ex_rd_we_q   <= bus.id_rd_we;
         ex_is_load_q <= bus.id_is_load;
      end else if (advance) begin
         ex_valid_q <= 1'b0;
      end
   end

   // Counts interlock cycles seen by a real instruction; a flushed slot is not a stall
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         stall_cnt <= '0;
      end else if (bus.id_valid && hazard && !flush && (stall_cnt != STALL_MAX)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end

   assign bus.ex_valid   = ex_valid_q;
   assign bus.ex_alu_op  = ex_alu_op_q;
   assign bus.ex_alu_a   = ex_alu_a_q;
   assign bus.ex_alu_b   = ex_alu_b_q;
   assign bus.ex_rd_addr = ex_rd_addr_q;
   assign bus.ex_rd_we   = ex_rd_we_q;
   assign bus.ex_is_load = ex_is_load_q;

endmodule

// File: tb/tb_otter_alu_issue.sv
// Self-checking bench for otter_alu_issue: scoreboard of expected ALU-side bundles
// consumed on the execute handshake, plus per-scenario inline checks.
module tb_otter_alu_issue;

   import otter_pkg::*;

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        we;
      logic        load;
   } exp_t;

   logic        CLK;
   logic        RST_N;
   logic [4:0]  mem_rd_addr;
   logic        mem_rd_we;
   logic        mem_data_ok;
   logic [31:0] mem_result;
   logic [4:0]  wb_rd_addr;
   logic        wb_rd_we;
   logic [31:0] wb_data;
   logic        flush;
   logic [15:0] stall_cnt;

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   otter_alu_issue_if bus_if ();

   otter_alu_issue dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .bus         (bus_if.slave),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_we   (mem_rd_we),
      .mem_data_ok (mem_data_ok),
      .mem_result  (mem_result),
      .wb_rd_addr  (wb_rd_addr),
      .wb_rd_we    (wb_rd_we),
      .wb_data     (wb_data),
      .flush       (flush),
      .stall_cnt   (stall_cnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Execute consumes the bundle on the next rising edge; compare it against the oldest expectation
   always @(negedge CLK) begin
      exp_t got;
      exp_t want;
      if (RST_N && bus_if.ex_valid && bus_if.ex_ready && !flush) begin
         got = '{bus_if.ex_alu_op, bus_if.ex_alu_a, bus_if.ex_alu_b,
                 bus_if.ex_rd_addr, bus_if.ex_rd_we, bus_if.ex_is_load};
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL sb_unexpected got %h required nothing", got);
         end else begin
            want = sb.pop_front();
            if (got !== want) begin
               errors++;
               $display("[TB] FAIL sb_item got %h required %h", got, want);
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s got %h required %h", name, got, want);
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic [1:0] asel, input logic [1:0] bsel,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [31:0] pc,
                        input logic [4:0] rd, input logic we, input logic load);
      bus_if.id_valid    = 1'b1;
      bus_if.id_alu_op   = op;
      bus_if.id_a_sel    = asel;
      bus_if.id_b_sel    = bsel;
      bus_if.id_rs1_addr = rs1;
      bus_if.id_rs2_addr = rs2;
      bus_if.id_rs1_data = d1;
      bus_if.id_rs2_data = d2;
      bus_if.id_imm      = imm;
      bus_if.id_pc       = pc;
      bus_if.id_rd_addr  = rd;
      bus_if.id_rd_we    = we;
      bus_if.id_is_load  = load;
   endtask

   task automatic idle();
      bus_if.id_valid = 1'b0;
   endtask

   task automatic clear_fwd();
      mem_rd_we   = 1'b0;
      mem_rd_addr = '0;
      mem_data_ok = 1'b1;
      mem_result  = '0;
      wb_rd_we    = 1'b0;
      wb_rd_addr  = '0;
      wb_data     = '0;
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      flush = 1'b0;
      bus_if.ex_ready  = 1'b1;
      bus_if.ex_result = '0;
      clear_fwd();
      drive(4'd0, 2'd3, 2'd3, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
      idle();
      #2;
      check("reset_ex_valid", {31'd0, bus_if.ex_valid}, 32'd0);
      check("reset_alu_a", bus_if.ex_alu_a, 32'd0);
      check("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
      flush = 1'b1;
      tick();
      check("reset_flush_noeffect", {31'd0, bus_if.ex_valid}, 32'd0);
      flush = 1'b0;
      RST_N = 1'b1;
      tick();
   endtask

   task automatic test_ex_forward();
      drive(ALU_ADD, SRC_IMM, SRC_ZERO, 5'd0, 5'd0, 32'd0, 32'd0, 32'd7, 32'd0, 5'd5, 1'b1, 1'b0);
      sb.push_back('{ALU_ADD, 32'd7, 32'd0, 5'd5, 1'b1, 1'b0});
      tick();
      check("exfwd_producer_valid", {31'd0, bus_if.ex_valid}, 32'd1);
      bus_if.ex_result = 32'h10;
      drive(ALU_ADD, SRC_RS, SRC_IMM, 5'd5, 5'd0, 32'h99, 32'd0, 32'd3, 32'd0, 5'd6, 1'b1, 1'b0);
      sb.push_back('{ALU_ADD, 32'h10, 32'd3, 5'd6, 1'b1, 1'b0});
      #1;
      check("exfwd_id_ready", {31'd0, bus_if.id_ready}, 32'd1);
      tick();
      check("exfwd_alu_a", bus_if.ex_alu_a, 32'h10);
      check("exfwd_ex_valid", {31'd0, bus_if.ex_valid}, 32'd1);
      idle();
      tick();
      check("exfwd_drained", {31'd0, bus_if.ex_valid}, 32'd0);
   endtask

   task automatic test_load_use();
      drive(ALU_ADD, SRC_RS, SRC_IMM, 5'd2, 5'd0, 32'h100, 32'd0, 32'd4, 32'd0, 5'd7, 1'b1, 1'b1);
      sb.push_back('{ALU_ADD, 32'h100, 32'd4, 5'd7, 1'b1, 1'b1});
      tick();
      drive(ALU_SUB, SRC_IMM, SRC_RS, 5'd0, 5'd7, 32'd0, 32'h55, 32'd1, 32'd0, 5'd9, 1'b1, 1'b0);
      #1;
      check("lu_ready_c1", {31'd0, bus_if.id_ready}, 32'd0);
      tick();
      check("lu_bubble_c1", {31'd0, bus_if.ex_valid}, 32'd0);
      check("lu_stall_c1", {16'd0, stall_cnt}, 32'd1);
      mem_rd_we   = 1'b1;
      mem_rd_addr = 5'd7;
      mem_data_ok = 1'b0;
      #1;
      check("lu_ready_c2", {31'd0, bus_if.id_ready}, 32'd0);
      tick();
      check("lu_bubble_c2", {31'd0, bus_if.ex_valid}, 32'd0);
      mem_data_ok = 1'b1;
      mem_result  = 32'hABCD;
      sb.push_back('{ALU_SUB, 32'd1, 32'hABCD, 5'd9, 1'b1, 1'b0});
      #1;
      check("lu_ready_c3", {31'd0, bus_if.id_ready}, 32'd1);
      tick();
      check("lu_alu_b", bus_if.ex_alu_b, 32'hABCD);
      check("lu_stall_cnt", {16'd0, stall_cnt}, 32'd2);
      idle();
      clear_fwd();
      tick();
   endtask

   task automatic test_x0_unused();
      drive(ALU_ADD, SRC_IMM, SRC_ZERO, 5'd0, 5'd0, 32'd0, 32'd0, 32'h77, 32'd0, 5'd0, 1'b1, 1'b1);
      sb.push_back('{ALU_ADD, 32'h77, 32'd0, 5'd0, 1'b1, 1'b1});
      tick();
      mem_rd_we   = 1'b1;
      mem_rd_addr = 5'd4;
      mem_data_ok = 1'b0;
      drive(ALU_OR, SRC_RS, SRC_IMM, 5'd0, 5'd4, 32'h1234, 32'h9999, 32'h5A5A, 32'd0, 5'd11, 1'b1, 1'b0);
      sb.push_back('{ALU_OR, 32'd0, 32'h5A5A, 5'd11, 1'b1, 1'b0});
      #1;
      check("x0_id_ready", {31'd0, bus_if.id_ready}, 32'd1);
      tick();
      check("x0_alu_a", bus_if.ex_alu_a, 32'd0);
      check("x0_alu_b", bus_if.ex_alu_b, 32'h5A5A);
      check("x0_stall_cnt", {16'd0, stall_cnt}, 32'd2);
      idle();
      clear_fwd();
      tick();
   endtask

   task automatic test_back_to_back();
      drive(ALU_XOR, SRC_PC, SRC_IMM, 5'd0, 5'd0, 32'd0, 32'd0, 32'h0F, 32'h1000, 5'd3, 1'b1, 1'b0);
      sb.push_back('{ALU_XOR, 32'h1000, 32'h0F, 5'd3, 1'b1, 1'b0});
      tick();
      bus_if.ex_ready = 1'b0;
      drive(ALU_OR, SRC_IMM, SRC_ZERO, 5'd0, 5'd0, 32'd0, 32'd0, 32'h22, 32'd0, 5'd4, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp_id_ready", {31'd0, bus_if.id_ready}, 32'd0);
         tick();
         check("bp_hold_a", bus_if.ex_alu_a, 32'h1000);
         check("bp_hold_op", {28'd0, bus_if.ex_alu_op}, {28'd0, ALU_XOR});
      end
      bus_if.ex_ready = 1'b1;
      sb.push_back('{ALU_OR, 32'h22, 32'd0, 5'd4, 1'b1, 1'b0});
      #1;
      check("bp_release_ready", {31'd0, bus_if.id_ready}, 32'd1);
      tick();
      check("bp_b_captured", bus_if.ex_alu_a, 32'h22);
      idle();
      tick();
   endtask

   task automatic test_flush_priority();
      drive(ALU_ADD, SRC_IMM, SRC_ZERO, 5'd0, 5'd0, 32'd0, 32'd0, 32'h5, 32'd0, 5'd12, 1'b1, 1'b1);
      tick();
      check("fl_held_valid", {31'd0, bus_if.ex_valid}, 32'd1);
      bus_if.ex_ready = 1'b0;
      flush = 1'b1;
      drive(ALU_ADD, SRC_RS, SRC_ZERO, 5'd12, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd13, 1'b1, 1'b0);
      #1;
      check("fl_id_ready", {31'd0, bus_if.id_ready}, 32'd0);
      tick();
      check("fl_ex_valid", {31'd0, bus_if.ex_valid}, 32'd0);
      check("fl_no_stall", {16'd0, stall_cnt}, 32'd2);
      flush = 1'b0;
      bus_if.ex_ready = 1'b1;
      idle();
      tick();
      check("fl_not_accepted", {31'd0, bus_if.ex_valid}, 32'd0);

      drive(ALU_ADD, SRC_IMM, SRC_ZERO, 5'd0, 5'd0, 32'd0, 32'd0, 32'h8, 32'd0, 5'd8, 1'b1, 1'b0);
      sb.push_back('{ALU_ADD, 32'h8, 32'd0, 5'd8, 1'b1, 1'b0});
      tick();
      bus_if.ex_result = 32'd1;
      mem_rd_we = 1'b1; mem_rd_addr = 5'd8; mem_data_ok = 1'b1; mem_result = 32'd2;
      wb_rd_we = 1'b1;  wb_rd_addr = 5'd8;  wb_data = 32'd3;
      drive(ALU_ADD, SRC_RS, SRC_ZERO, 5'd8, 5'd0, 32'hFF, 32'd0, 32'd0, 32'd0, 5'd1, 1'b0, 1'b0);
      sb.push_back('{ALU_ADD, 32'd1, 32'd0, 5'd1, 1'b0, 1'b0});
      tick();
      check("prio_ex", bus_if.ex_alu_a, 32'd1);
      sb.push_back('{ALU_ADD, 32'd2, 32'd0, 5'd1, 1'b0, 1'b0});
      tick();
      check("prio_mem", bus_if.ex_alu_a, 32'd2);
      mem_rd_we = 1'b0;
      sb.push_back('{ALU_ADD, 32'd3, 32'd0, 5'd1, 1'b0, 1'b0});
      tick();
      check("prio_wb", bus_if.ex_alu_a, 32'd3);
      idle();
      clear_fwd();
      tick();
   endtask

   task automatic test_reset_midstream();
      drive(ALU_AND, SRC_IMM, SRC_IMM, 5'd0, 5'd0, 32'd0, 32'd0, 32'hCAFE, 32'd0, 5'd14, 1'b1, 1'b1);
      tick();
      bus_if.ex_ready = 1'b0;
      idle();
      check("mid_valid_before", {31'd0, bus_if.ex_valid}, 32'd1);
      #1;
      RST_N = 1'b0;
      #1;
      check("mid_ex_valid", {31'd0, bus_if.ex_valid}, 32'd0);
      check("mid_alu_a", bus_if.ex_alu_a, 32'd0);
      check("mid_rd_addr", {27'd0, bus_if.ex_rd_addr}, 32'd0);
      check("mid_is_load", {31'd0, bus_if.ex_is_load}, 32'd0);
      check("mid_stall_cnt", {16'd0, stall_cnt}, 32'd0);
      tick();
      RST_N = 1'b1;
      bus_if.ex_ready = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_ex_forward();
      test_load_use();
      test_x0_unused();
      test_back_to_back();
      test_flush_priority();
      test_reset_midstream();
      check("sb_empty", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
